// File: rtl/pixel_scheduler.sv
// pixel_scheduler
//   Frame-level controller for a bank of mandelbrot_engine instances.
//   It raster-scans the screen and hands one coordinate at a time to idle
//   engines in round-robin order. A second, independent round-robin arbiter
//   collects finished results into a single valid/ready output register.
//   frame_done pulses once every pixel of the frame has been retired downstream.
//
// Optional feature macro: PIXEL_SCHEDULER_PERF_COUNTERS_EN
//   Defined   : frame_cycles counts the busy cycles of the current/last frame,
//               saturating at 32'hFFFF_FFFF.
//   Undefined : frame_cycles is tied to 0. The port list is the same in both builds.
//
// Ports
//   clk, reset        : single clock, synchronous active-high reset
//   start             : frame start pulse (ignored while busy)
//   busy, frame_done  : frame status (registered)
//   eng_ready         : per-engine "can accept a coordinate"
//   eng_load, x0, y0  : registered one-hot load strobe and shared coordinate bus
//   eng_done          : per-engine result valid (held until acknowledged)
//   eng_iterations,
//   eng_xpixel,
//   eng_ypixel        : packed per-engine results, engine i at [i*W +: W]
//   eng_ack           : combinational one-hot result acknowledge
//   out_valid/out_ready, out_x, out_y, out_iterations : downstream stream
//   frame_cycles      : performance counter
module pixel_scheduler #(
    parameter int NUM_ENGINES      = 4,
    parameter int PIXEL_DATA_WIDTH = 10,
    parameter int ITERATIONS_WIDTH = 9,
    parameter int SCREEN_WIDTH     = 640,
    parameter int SCREEN_HEIGHT    = 480
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    output logic                                     busy,
    output logic                                     frame_done,
    input  logic [NUM_ENGINES-1:0]                   eng_ready,
    output logic [NUM_ENGINES-1:0]                   eng_load,
    output logic [PIXEL_DATA_WIDTH-1:0]              x0,
    output logic [PIXEL_DATA_WIDTH-1:0]              y0,
    input  logic [NUM_ENGINES-1:0]                   eng_done,
    input  logic [NUM_ENGINES*ITERATIONS_WIDTH-1:0]  eng_iterations,
    input  logic [NUM_ENGINES*PIXEL_DATA_WIDTH-1:0]  eng_xpixel,
    input  logic [NUM_ENGINES*PIXEL_DATA_WIDTH-1:0]  eng_ypixel,
    output logic [NUM_ENGINES-1:0]                   eng_ack,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [PIXEL_DATA_WIDTH-1:0]              out_x,
    output logic [PIXEL_DATA_WIDTH-1:0]              out_y,
    output logic [ITERATIONS_WIDTH-1:0]              out_iterations,
    output logic [31:0]                              frame_cycles
);

    localparam int TOTAL = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int PTR_W = $clog2(NUM_ENGINES);
    localparam int PW    = PIXEL_DATA_WIDTH;
    localparam int IW    = ITERATIONS_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN} state_t;

    // Round-robin pick: ptr is the highest-priority index, the search wraps.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_ENGINES-1:0] req,
                                                 input logic [PTR_W-1:0]       ptr);
        logic [PTR_W-1:0] pick;
        int idx;
        pick = ptr;
        for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_ENGINES;
            if (req[idx]) pick = PTR_W'(idx);
        end
        return pick;
    endfunction

    function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] idx);
        return PTR_W'((int'(idx) + 1) % NUM_ENGINES);
    endfunction

    state_t                 state_q, state_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;
    logic [NUM_ENGINES-1:0] eng_load_q, eng_load_d;
    logic [PW-1:0]          x0_q, x0_d, y0_q, y0_d;
    logic [PW-1:0]          scan_x_q, scan_x_d, scan_y_q, scan_y_d;
    logic [PTR_W-1:0]       dptr_q, dptr_d, cptr_q, cptr_d;
    logic [CNT_W-1:0]       retire_q, retire_d;
    logic                   out_valid_q, out_valid_d;
    logic [PW-1:0]          out_x_q, out_x_d, out_y_q, out_y_d;
    logic [IW-1:0]          out_it_q, out_it_d;

    logic                   dispatching, disp_grant, last_pixel, capture;
    logic [NUM_ENGINES-1:0] elig;
    logic [PTR_W-1:0]       disp_idx, col_idx;
    logic [PW-1:0]          scan_x, scan_y;

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        eng_load_d   = '0;
        x0_d         = x0_q;
        y0_d         = y0_q;
        scan_x_d     = scan_x_q;
        scan_y_d     = scan_y_q;
        dptr_d       = dptr_q;
        cptr_d       = cptr_q;
        retire_d     = retire_q;
        out_valid_d  = out_valid_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_it_d     = out_it_q;
        eng_ack      = '0;

        // An accepted start dispatches pixel (0,0) in the same cycle so the
        // first load appears together with busy.
        dispatching = (state_q == S_DISPATCH) || (state_q == S_IDLE && start);
        scan_x      = (state_q == S_IDLE) ? '0 : scan_x_q;
        scan_y      = (state_q == S_IDLE) ? '0 : scan_y_q;
        // Engine ready lags its load by a cycle; mask engines loaded last cycle.
        elig        = eng_ready & ~eng_load_q;
        disp_grant  = dispatching && (elig != '0);
        disp_idx    = rr_pick(elig, dptr_q);
        last_pixel  = (scan_x == PW'(SCREEN_WIDTH - 1)) && (scan_y == PW'(SCREEN_HEIGHT - 1));

        if (dispatching) begin
            scan_x_d = scan_x;
            scan_y_d = scan_y;
        end
        if (disp_grant) begin
            eng_load_d[disp_idx] = 1'b1;
            x0_d   = scan_x;
            y0_d   = scan_y;
            dptr_d = rr_next(disp_idx);
            if (scan_x == PW'(SCREEN_WIDTH - 1)) begin
                scan_x_d = '0;
                scan_y_d = scan_y + PW'(1);
            end else begin
                scan_x_d = scan_x + PW'(1);
            end
        end

        if (state_q != S_IDLE && out_valid_q && out_ready)
            retire_d = retire_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    retire_d = '0;
                    state_d  = (disp_grant && last_pixel) ? S_DRAIN : S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (disp_grant && last_pixel) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_valid_q && out_ready && retire_q == CNT_W'(TOTAL - 1)) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);

        // Collect: capture when the output register is empty or draining now.
        col_idx = rr_pick(eng_done, cptr_q);
        capture = (!out_valid_q || out_ready) && (eng_done != '0);
        if (capture) begin
            eng_ack[col_idx] = 1'b1;
            cptr_d      = rr_next(col_idx);
            out_valid_d = 1'b1;
            out_x_d     = eng_xpixel[int'(col_idx)*PW +: PW];
            out_y_d     = eng_ypixel[int'(col_idx)*PW +: PW];
            out_it_d    = eng_iterations[int'(col_idx)*IW +: IW];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            eng_load_q   <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            scan_x_q     <= '0;
            scan_y_q     <= '0;
            dptr_q       <= '0;
            cptr_q       <= '0;
            retire_q     <= '0;
            out_valid_q  <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_it_q     <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            eng_load_q   <= eng_load_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            scan_x_q     <= scan_x_d;
            scan_y_q     <= scan_y_d;
            dptr_q       <= dptr_d;
            cptr_q       <= cptr_d;
            retire_q     <= retire_d;
            out_valid_q  <= out_valid_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_it_q     <= out_it_d;
        end
    end

`ifdef PIXEL_SCHEDULER_PERF_COUNTERS_EN
    logic [31:0] frame_cycles_q, frame_cycles_d;

    // Counts busy cycles; stops by itself when busy falls with frame_done.
    always_comb begin
        frame_cycles_d = frame_cycles_q;
        if (state_q == S_IDLE && start)
            frame_cycles_d = '0;
        else if (busy_q && frame_cycles_q != 32'hFFFF_FFFF)
            frame_cycles_d = frame_cycles_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) frame_cycles_q <= '0;
        else       frame_cycles_q <= frame_cycles_d;
    end

    assign frame_cycles = frame_cycles_q;
`else
    assign frame_cycles = '0;
`endif

    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign eng_load       = eng_load_q;
    assign x0             = x0_q;
    assign y0             = y0_q;
    assign out_valid      = out_valid_q;
    assign out_x          = out_x_q;
    assign out_y          = out_y_q;
    assign out_iterations = out_it_q;

endmodule

// File: tb/tb_pixel_scheduler.sv
// Testbench for pixel_scheduler: 2 engines, 4x2 screen. Engines are modelled
// as per-engine result queues; the expected pixel stream is derived from the
// raster-order rule and a set of outstanding pixels.
module tb_pixel_scheduler;

    localparam int NE = 2, PW = 10, IW = 9, SW = 4, SH = 2, NPIX = SW * SH;

    logic              clk = 1'b0;
    logic              reset, start;
    logic              busy, frame_done;
    logic [NE-1:0]     eng_ready, eng_load, eng_done, eng_ack;
    logic [PW-1:0]     x0, y0, out_x, out_y;
    logic [NE*IW-1:0]  eng_iterations;
    logic [NE*PW-1:0]  eng_xpixel, eng_ypixel;
    logic              out_valid, out_ready;
    logic [IW-1:0]     out_iterations;
    logic [31:0]       frame_cycles;

    always #5 clk = ~clk;

    pixel_scheduler #(
        .NUM_ENGINES(NE), .PIXEL_DATA_WIDTH(PW), .ITERATIONS_WIDTH(IW),
        .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done),
        .eng_ready(eng_ready), .eng_load(eng_load), .x0(x0), .y0(y0),
        .eng_done(eng_done), .eng_iterations(eng_iterations),
        .eng_xpixel(eng_xpixel), .eng_ypixel(eng_ypixel), .eng_ack(eng_ack),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
        .out_iterations(out_iterations), .frame_cycles(frame_cycles)
    );

    typedef struct {
        int eng;
        int x;
        int y;
        int rdy;
    } job_t;

    job_t      jobs[$];
    bit        pend[int];
    int        checks = 0, errors = 0, cyc = 0;
    int        load_idx, retired, fd_count, fd_cyc, hold_seen, inj_n;
    logic [1:0] ready_en, prev_load, prev_ready, last_ack;
    bit        rand_ready, rand_out, lat_rand, prev_hold;
    int        load_mode, stall_from, stall_to;
    logic [PW-1:0] px, py;
    logic [IW-1:0] pit;

    function automatic logic [IW-1:0] iter_of(input int x, input int y);
        return IW'((x * 37 + y * 11 + 5) % 512);
    endfunction

    task automatic clear_model();
        jobs.delete();
        pend.delete();
        prev_hold = 1'b0;
        load_idx  = 0;
        retired   = 0;
        fd_count  = 0;
        hold_seen = 0;
    endtask

    task automatic drive_inputs();
        logic [NE-1:0]    d;
        logic [NE*IW-1:0] it;
        logic [NE*PW-1:0] xs, ys;
        d = '0; it = '0; xs = '0; ys = '0;
        for (int i = 0; i < NE; i++) begin
            for (int j = 0; j < jobs.size(); j++) begin
                if (jobs[j].eng == i) begin
                    it[i*IW +: IW] = iter_of(jobs[j].x, jobs[j].y);
                    xs[i*PW +: PW] = PW'(jobs[j].x);
                    ys[i*PW +: PW] = PW'(jobs[j].y);
                    d[i] = (jobs[j].rdy <= cyc);
                    break;
                end
            end
        end
        eng_done = d; eng_iterations = it; eng_xpixel = xs; eng_ypixel = ys;
        eng_ready = rand_ready ? 2'($urandom_range(0, 3)) : ready_en;
        if (cyc >= stall_from && cyc < stall_to) out_ready = 1'b0;
        else out_ready = rand_out ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic inject(input int e);
        job_t jb;
        jb.eng = e; jb.x = 100 + inj_n; jb.y = 200 + e; jb.rdy = cyc;
        inj_n++;
        jobs.push_back(jb);
        pend[jb.x * 1024 + jb.y] = 1'b1;
    endtask

    // One clock cycle: drive engine/downstream inputs, observe mid-cycle,
    // update the engine and scoreboard model, advance past the next edge.
    task automatic cycle();
        int   e, key;
        bit   exp_any;
        job_t jb;
        drive_inputs();
        @(negedge clk);
        if (eng_load != '0) begin
            checks++;
            if (!$onehot(eng_load) || ((eng_load & prev_ready & ~prev_load) != eng_load)) begin
                errors++;
                $display("FAIL load_legal cyc=%0d eng_load=%b prev_ready=%b prev_load=%b",
                         cyc, eng_load, prev_ready, prev_load);
            end
            e = eng_load[1] ? 1 : 0;
            checks++;
            if (x0 !== PW'(load_idx % SW) || y0 !== PW'(load_idx / SW)) begin
                errors++;
                $display("FAIL load_order idx=%0d got (%0d,%0d) want (%0d,%0d)",
                         load_idx, x0, y0, load_idx % SW, load_idx / SW);
            end
            if (load_mode == 1) begin
                checks++;
                if (e != load_idx % 2) begin
                    errors++;
                    $display("FAIL load_rr idx=%0d got eng %0d want eng %0d", load_idx, e, load_idx % 2);
                end
            end else if (load_mode == 2) begin
                checks++;
                if (e != 1) begin
                    errors++;
                    $display("FAIL load_single idx=%0d got eng %0d want eng 1", load_idx, e);
                end
            end
            jb.eng = e; jb.x = int'(x0); jb.y = int'(y0);
            jb.rdy = cyc + (lat_rand ? int'($urandom_range(1, 6)) : 3);
            jobs.push_back(jb);
            pend[jb.x * 1024 + jb.y] = 1'b1;
            load_idx++;
        end

        checks++;
        exp_any = (eng_done != '0) && (!out_valid || out_ready);
        if (((eng_ack != '0) != exp_any) ||
            (eng_ack != '0 && (!$onehot(eng_ack) || (eng_ack & ~eng_done) != '0))) begin
            errors++;
            $display("FAIL ack cyc=%0d eng_ack=%b eng_done=%b out_valid=%b out_ready=%b",
                     cyc, eng_ack, eng_done, out_valid, out_ready);
        end
        last_ack = eng_ack;
        if (eng_ack != '0) begin
            e = eng_ack[1] ? 1 : 0;
            for (int j = 0; j < jobs.size(); j++) begin
                if (jobs[j].eng == e) begin
                    jobs.delete(j);
                    break;
                end
            end
        end

        if (prev_hold) begin
            checks++;
            hold_seen++;
            if (out_valid !== 1'b1 || out_x !== px || out_y !== py || out_iterations !== pit) begin
                errors++;
                $display("FAIL hold cyc=%0d got v=%b (%0d,%0d,%0d) want v=1 (%0d,%0d,%0d)",
                         cyc, out_valid, out_x, out_y, out_iterations, px, py, pit);
            end
        end

        if (out_valid && out_ready) begin
            checks++;
            key = int'(out_x) * 1024 + int'(out_y);
            if (!pend.exists(key) || out_iterations !== iter_of(int'(out_x), int'(out_y))) begin
                errors++;
                $display("FAIL out_pixel cyc=%0d got (%0d,%0d,%0d) outstanding=%0d want iter %0d",
                         cyc, out_x, out_y, out_iterations, pend.exists(key),
                         iter_of(int'(out_x), int'(out_y)));
            end else begin
                pend.delete(key);
            end
            retired++;
        end

        if (frame_done) begin
            fd_count++;
            fd_cyc = cyc;
            checks++;
            if (busy !== 1'b0 || retired != NPIX || load_idx != NPIX) begin
                errors++;
                $display("FAIL frame_done cyc=%0d busy=%b retired=%0d loads=%0d want busy=0 %0d/%0d",
                         cyc, busy, retired, load_idx, NPIX, NPIX);
            end
        end

        prev_hold  = out_valid && !out_ready;
        px = out_x; py = out_y; pit = out_iterations;
        prev_load  = eng_load;
        prev_ready = eng_ready;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_frame(output int ts, output int tf);
        int n;
        load_idx = 0; retired = 0; fd_count = 0; fd_cyc = -1; hold_seen = 0;
        start = 1'b1;
        ts = cyc;
        cycle();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise got %b want 1", busy);
        end
        n = 0;
        while (fd_count == 0 && n < 3000) begin
            cycle();
            n++;
        end
        if (fd_count == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout loads=%0d retired=%0d want frame_done", load_idx, retired);
        end
        tf = fd_cyc;
        repeat (3) cycle();
        checks++;
        if (fd_count != 1 || busy !== 1'b0 || retired != NPIX || pend.size() != 0) begin
            errors++;
            $display("FAIL frame_end pulses=%0d busy=%b retired=%0d outstanding=%0d want 1,0,%0d,0",
                     fd_count, busy, retired, pend.size(), NPIX);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cycle();
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || eng_load !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl busy=%b fd=%b load=%b ov=%b want all 0", busy, frame_done, eng_load, out_valid);
        end
        checks++;
        if (x0 !== '0 || y0 !== '0 || out_x !== '0 || out_y !== '0 || out_iterations !== '0 || frame_cycles !== '0) begin
            errors++;
            $display("FAIL reset_data x0=%0d y0=%0d ox=%0d oy=%0d oi=%0d fc=%0d want all 0",
                     x0, y0, out_x, out_y, out_iterations, frame_cycles);
        end
        reset = 1'b0;
        clear_model();
    endtask

    task automatic test_small_frame();
        int ts, tf;
        ready_en = 2'b11; rand_ready = 0; rand_out = 0; lat_rand = 0; load_mode = 1;
        run_frame(ts, tf);
        load_mode = 0;
    endtask

    task automatic test_stall();
        int ts, tf;
        ready_en = 2'b11; lat_rand = 1;
        stall_from = cyc + 10;
        stall_to   = cyc + 30;
        run_frame(ts, tf);
        checks++;
        if (hold_seen < 15) begin
            errors++;
            $display("FAIL stall_held held_cycles=%0d want >=15", hold_seen);
        end
        stall_from = -1; stall_to = -1; lat_rand = 0;
    endtask

    task automatic test_single_engine();
        int ts, tf;
        ready_en = 2'b10; load_mode = 2;
        run_frame(ts, tf);
        load_mode = 0; ready_en = 2'b11;
    endtask

    task automatic test_simultaneous();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        clear_model();
        inj_n = 0;
        inject(1);
        cycle();
        checks++;
        if (last_ack !== 2'b10) begin errors++; $display("FAIL sim_ack_a got %b want 10", last_ack); end
        cycle();
        inject(0); inject(1);
        cycle();
        checks++;
        if (last_ack !== 2'b01) begin errors++; $display("FAIL sim_ack_b got %b want 01", last_ack); end
        cycle();
        checks++;
        if (last_ack !== 2'b10) begin errors++; $display("FAIL sim_ack_c got %b want 10", last_ack); end
        cycle();
        inject(0);
        cycle();
        checks++;
        if (last_ack !== 2'b01) begin errors++; $display("FAIL sim_ack_d got %b want 01", last_ack); end
        cycle();
        inject(0); inject(1);
        cycle();
        checks++;
        if (last_ack !== 2'b10) begin errors++; $display("FAIL sim_ack_e got %b want 10", last_ack); end
        cycle();
        checks++;
        if (last_ack !== 2'b01) begin errors++; $display("FAIL sim_ack_f got %b want 01", last_ack); end
        repeat (3) cycle();
        checks++;
        if (pend.size() != 0 || jobs.size() != 0) begin
            errors++;
            $display("FAIL sim_emitted outstanding=%0d engine_jobs=%0d want 0,0", pend.size(), jobs.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int n, ts, tf;
        ready_en = 2'b11;
        clear_model();
        start = 1'b1;
        cycle();
        start = 1'b0;
        n = 0;
        while (load_idx < 3 && n < 100) begin
            cycle();
            n++;
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        clear_model();
        drive_inputs();
        #1;
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || eng_load !== '0 || out_valid !== 1'b0 ||
            x0 !== '0 || y0 !== '0 || out_x !== '0 || out_y !== '0 || out_iterations !== '0 ||
            frame_cycles !== '0) begin
            errors++;
            $display("FAIL midreset_zero busy=%b fd=%b load=%b ov=%b x0=%0d y0=%0d ox=%0d oy=%0d oi=%0d fc=%0d want all 0",
                     busy, frame_done, eng_load, out_valid, x0, y0, out_x, out_y, out_iterations, frame_cycles);
        end
        repeat (10) cycle();
        checks++;
        if (fd_count != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_nodone pulses=%0d busy=%b want 0,0", fd_count, busy);
        end
        run_frame(ts, tf);
    endtask

    task automatic test_random();
        int ts, tf;
        rand_ready = 1; rand_out = 1; lat_rand = 1;
        repeat (3) run_frame(ts, tf);
        rand_ready = 0; rand_out = 0; lat_rand = 0;
    endtask

    task automatic test_counter();
        int ts, tf, exp_fc;
        ready_en = 2'b11; rand_out = 1;
        run_frame(ts, tf);
        rand_out = 0;
`ifdef PIXEL_SCHEDULER_PERF_COUNTERS_EN
        exp_fc = tf - ts - 1;
`else
        exp_fc = 0;
`endif
        checks++;
        if (frame_cycles !== 32'(exp_fc)) begin
            errors++;
            $display("FAIL counter got %0d want %0d", frame_cycles, exp_fc);
        end
        repeat (5) cycle();
        checks++;
        if (frame_cycles !== 32'(exp_fc)) begin
            errors++;
            $display("FAIL counter_hold got %0d want %0d", frame_cycles, exp_fc);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        eng_ready = '0; eng_done = '0; eng_iterations = '0; eng_xpixel = '0; eng_ypixel = '0;
        ready_en = 2'b11; rand_ready = 0; rand_out = 0; lat_rand = 0; load_mode = 0;
        stall_from = -1; stall_to = -1; inj_n = 0; fd_cyc = -1;
        prev_load = '0; prev_ready = '0; last_ack = '0;
        clear_model();
        test_reset();
        test_small_frame();
        test_stall();
        test_single_engine();
        test_simultaneous();
        test_reset_mid_frame();
        test_random();
        test_counter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
